// File: rtl/mem_pkg.sv
// Shared types and constants for the 64-bit pipeline memory-access stage.
// Holds the access-size encodings, the FSM states and the lane-mask helpers.
package mem_pkg;

  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction

  // Byte strobes for an access of 2**size bytes starting at lane off.
  // Lanes past 7 fall off the top.
  function automatic logic [STRB_W-1:0] lane_strb(input logic [1:0] size,
                                                  input logic [2:0] off);
    logic [15:0] base;
    base = 16'((16'd1 << (4'd1 << size)) - 16'd1);
    return STRB_W'(base << off);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: shifts the addressed lanes of a 64-bit read beat
// down to bit 0, then zero- or sign-extends them to the access size.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        off,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;

  // NOTE: every variable written here gets a value before any branch,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    data    = shifted;
    case (size_e'(size))
      SZ_BYTE:   data = unsigned_ld ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                    : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      SZ_HALF:   data = unsigned_ld ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                    : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      SZ_WORD:   data = unsigned_ld ? {{(DATA_W-32){1'b0}}, shifted[31:0]}
                                    : {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      default:   data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, request/ack data-memory access with lane
// alignment, MEM/WB register. MEM_ALIGN_CHECK_EN enables the misalignment trap.
module mem_stage
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] pc_plus_imm,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rd2,
  input  logic [31:0]       wr,
  input  logic              zero,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic              branch,
  input  logic              unsigned_ld,
  input  logic [1:0]        size,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [STRB_W-1:0] dmem_wstrb,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [31:0]       wb_wr,
  output logic              misalign_err
);

  state_e            state;
  logic              memop;
  logic              misaligned;
  logic              issue;
  logic [2:0]        off;
  logic [DATA_W-1:0] load_data;
  logic              unused_pc;

  assign unused_pc     = ^pc;
  assign memop         = in_valid & (mem_read | mem_write);
  assign off           = alu_result[2:0];
  assign pc_src        = in_valid & branch & zero;
  assign branch_target = pc_plus_imm;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |(off & size_mask(size));
`else
  assign misaligned = 1'b0;
`endif

  assign issue = memop & ~misaligned;

  // Upstream is held from the first memop cycle until the ack cycle.
  always_comb begin
    stall = 1'b0;
    if (state == IDLE) stall = issue;
    else               stall = ~dmem_ack;
  end

  mem_load_align u_load_align (
    .rdata       (dmem_rdata),
    .off         (off),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .data        (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_wstrb    <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_wr         <= '0;
      misalign_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            dmem_req     <= 1'b1;
            dmem_we      <= mem_write;
            dmem_addr    <= alu_result;
            dmem_wdata   <= rd2 << {off, 3'b000};
            dmem_wstrb   <= lane_strb(size, off);
            // Bubble into write-back while the access is outstanding.
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            misalign_err <= 1'b0;
            state        <= WAIT;
          end else begin
            wb_valid      <= in_valid;
            wb_reg_write  <= reg_write & ~(memop & misaligned);
            wb_mem_to_reg <= mem_to_reg;
            wb_read_data  <= '0;
            wb_alu_result <= alu_result;
            wb_wr         <= wr;
            misalign_err  <= memop & misaligned;
          end
        end
        WAIT: begin
          misalign_err <= 1'b0;
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            wb_valid      <= in_valid;
            wb_reg_write  <= reg_write;
            wb_mem_to_reg <= mem_to_reg;
            wb_read_data  <= dmem_we ? '0 : load_data;
            wb_alu_result <= alu_result;
            wb_wr         <= wr;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; build with +define+MEM_ALIGN_CHECK_EN
// to exercise the misalignment trap instead of lane truncation.
module tb_mem_stage;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [63:0]       pc, pc_plus_imm, alu_result, rd2;
  logic [31:0]       wr;
  logic              zero, mem_read, mem_write, mem_to_reg, reg_write, branch, unsigned_ld;
  logic [1:0]        size;
  logic              stall, pc_src;
  logic [63:0]       branch_target;
  logic              dmem_req, dmem_we;
  logic [63:0]       dmem_addr, dmem_wdata;
  logic [7:0]        dmem_wstrb;
  logic              dmem_ack;
  logic [63:0]       dmem_rdata;
  logic              wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [63:0]       wb_read_data, wb_alu_result;
  logic [31:0]       wb_wr;
  logic              misalign_err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc(pc), .pc_plus_imm(pc_plus_imm),
    .alu_result(alu_result), .rd2(rd2), .wr(wr), .zero(zero), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch),
    .unsigned_ld(unsigned_ld), .size(size), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_wr(wb_wr), .misalign_err(misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; pc = 64'h100; pc_plus_imm = '0; alu_result = '0; rd2 = '0; wr = '0;
    zero = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0; branch = 0;
    unsigned_ld = 0; size = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    dmem_ack = 0; dmem_rdata = '0;
    rst_n = 1; #1 rst_n = 0; #2;
    checks++; if (dmem_req !== 1'b0) $display("FAIL reset_req: got %0h want 0", dmem_req); else passes++;
    checks++; if (dmem_wstrb !== 8'h00) $display("FAIL reset_wstrb: got %0h want 0", dmem_wstrb); else passes++;
    checks++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %0h want 0", wb_valid); else passes++;
    checks++; if (wb_read_data !== 64'h0) $display("FAIL reset_rdata: got %0h want 0", wb_read_data); else passes++;
    checks++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign: got %0h want 0", misalign_err); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %0h want 0", stall); else passes++;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic test_alu();
    in_valid = 1; alu_result = 64'h2A; reg_write = 1; wr = 32'd5;
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL alu_stall: got %0h want 0", stall); else passes++;
    step();
    idle_inputs();
    checks++; if (wb_alu_result !== 64'h2A) $display("FAIL alu_result: got %0h want 2a", wb_alu_result); else passes++;
    checks++; if (wb_valid !== 1'b1) $display("FAIL alu_wb_valid: got %0h want 1", wb_valid); else passes++;
    checks++; if (wb_reg_write !== 1'b1) $display("FAIL alu_reg_write: got %0h want 1", wb_reg_write); else passes++;
    checks++; if (wb_wr !== 32'd5) $display("FAIL alu_wr: got %0h want 5", wb_wr); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL alu_stall_after: got %0h want 0", stall); else passes++;
  endtask

  task automatic test_branch();
    in_valid = 1; branch = 1; zero = 1; pc_plus_imm = 64'h400;
    #1;
    checks++; if (pc_src !== 1'b1) $display("FAIL br_taken: got %0h want 1", pc_src); else passes++;
    checks++; if (branch_target !== 64'h400) $display("FAIL br_target: got %0h want 400", branch_target); else passes++;
    zero = 0;
    #1;
    checks++; if (pc_src !== 1'b0) $display("FAIL br_not_taken: got %0h want 0", pc_src); else passes++;
    idle_inputs();
    step();
  endtask

  task automatic do_store(input string name, input logic [63:0] addr, input logic [1:0] sz,
                          input logic [63:0] data, input logic [7:0] exp_strb,
                          input logic [63:0] exp_wdata, input int waits);
    int n;
    in_valid = 1; mem_write = 1; alu_result = addr; size = sz; rd2 = data;
    #1;
    n = int'(stall);
    step();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) $display("FAIL %s_req: got req=%0h we=%0h want 1 1", name, dmem_req, dmem_we); else passes++;
    checks++; if (dmem_addr !== addr) $display("FAIL %s_addr: got %0h want %0h", name, dmem_addr, addr); else passes++;
    checks++; if (dmem_wstrb !== exp_strb) $display("FAIL %s_wstrb: got %0h want %0h", name, dmem_wstrb, exp_strb); else passes++;
    checks++; if (dmem_wdata !== exp_wdata) $display("FAIL %s_wdata: got %0h want %0h", name, dmem_wdata, exp_wdata); else passes++;
    repeat (waits) begin
      n += int'(stall);
      step();
    end
    dmem_ack = 1;
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL %s_ack_stall: got %0h want 0", name, stall); else passes++;
    step();
    dmem_ack = 0;
    idle_inputs();
    checks++; if (n != waits + 1) $display("FAIL %s_stall_cycles: got %0d want %0d", name, n, waits + 1); else passes++;
    checks++; if (dmem_req !== 1'b0) $display("FAIL %s_req_clear: got %0h want 0", name, dmem_req); else passes++;
    checks++; if (wb_valid !== 1'b1 || wb_read_data !== 64'h0) $display("FAIL %s_wb: got valid=%0h data=%0h want 1 0", name, wb_valid, wb_read_data); else passes++;
  endtask

  task automatic test_store();
    do_store("st_word", 64'h1004, 2'b10, 64'hDEADBEEF, 8'hF0, 64'hDEADBEEF_00000000, 3);
    do_store("st_byte", 64'h1007, 2'b00, 64'hAB, 8'h80, 64'hAB000000_00000000, 0);
    do_store("st_half", 64'h1002, 2'b01, 64'h1111_2222_3333_BEEF, 8'h0C, 64'h2222_3333_BEEF_0000, 1);
    do_store("st_dbl", 64'h1000, 2'b11, 64'h01234567_89ABCDEF, 8'hFF, 64'h01234567_89ABCDEF, 1);
  endtask

  task automatic do_load(input string name, input logic [63:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
    in_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1; wr = 32'd9;
    alu_result = addr; size = sz; unsigned_ld = uns;
    step();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) $display("FAIL %s_req: got req=%0h we=%0h want 1 0", name, dmem_req, dmem_we); else passes++;
    dmem_ack = 1; dmem_rdata = rdata;
    step();
    dmem_ack = 0; dmem_rdata = '0;
    idle_inputs();
    checks++; if (wb_read_data !== exp) $display("FAIL %s_data: got %0h want %0h", name, wb_read_data, exp); else passes++;
    checks++; if (wb_valid !== 1'b1 || wb_mem_to_reg !== 1'b1 || wb_wr !== 32'd9) $display("FAIL %s_wb: got valid=%0h m2r=%0h wr=%0h want 1 1 9", name, wb_valid, wb_mem_to_reg, wb_wr); else passes++;
  endtask

  task automatic test_load();
    do_load("ld_b_s", 64'h1003, 2'b00, 1'b0, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
    do_load("ld_b_u", 64'h1003, 2'b00, 1'b1, 64'h00000000_80000000, 64'h00000000_00000080);
    do_load("ld_h_s", 64'h1006, 2'b01, 1'b0, 64'h8001_0000_0000_0000, 64'hFFFFFFFF_FFFF8001);
    do_load("ld_w_s", 64'h1000, 2'b10, 1'b0, 64'h00000000_87654321, 64'hFFFFFFFF_87654321);
    do_load("ld_w_u", 64'h1004, 2'b10, 1'b1, 64'h87654321_00000000, 64'h00000000_87654321);
    do_load("ld_d",   64'h1008, 2'b11, 1'b0, 64'hCAFEBABE_01234567, 64'hCAFEBABE_01234567);
  endtask

  task automatic test_reset_mid_access();
    in_valid = 1; mem_read = 1; reg_write = 1; alu_result = 64'h1000; size = 2'b11;
    step();
    checks++; if (dmem_req !== 1'b1 || stall !== 1'b1) $display("FAIL rst_mid_issue: got req=%0h stall=%0h want 1 1", dmem_req, stall); else passes++;
    rst_n = 0;
    #1;
    checks++; if (dmem_req !== 1'b0) $display("FAIL rst_mid_req: got %0h want 0", dmem_req); else passes++;
    idle_inputs();
    #2 rst_n = 1;
    dmem_ack = 1; dmem_rdata = 64'hFFFFFFFF_FFFFFFFF;
    step();
    checks++; if (wb_valid !== 1'b0 || wb_read_data !== 64'h0) $display("FAIL rst_mid_wb: got valid=%0h data=%0h want 0 0", wb_valid, wb_read_data); else passes++;
    checks++; if (dmem_req !== 1'b0) $display("FAIL rst_mid_late_ack: got %0h want 0", dmem_req); else passes++;
    dmem_ack = 0; dmem_rdata = '0;
    step();
  endtask

  task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
    in_valid = 1; mem_read = 1; reg_write = 1; alu_result = 64'h1001; size = 2'b01;
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL mis_stall: got %0h want 0", stall); else passes++;
    step();
    idle_inputs();
    checks++; if (dmem_req !== 1'b0) $display("FAIL mis_req: got %0h want 0", dmem_req); else passes++;
    checks++; if (misalign_err !== 1'b1) $display("FAIL mis_err: got %0h want 1", misalign_err); else passes++;
    checks++; if (wb_reg_write !== 1'b0 || wb_valid !== 1'b1) $display("FAIL mis_wb: got rw=%0h valid=%0h want 0 1", wb_reg_write, wb_valid); else passes++;
    step();
    checks++; if (misalign_err !== 1'b0) $display("FAIL mis_pulse: got %0h want 0", misalign_err); else passes++;
`else
    do_store("st_trunc", 64'h1004, 2'b11, 64'h01234567_89ABCDEF, 8'hF0, 64'h89ABCDEF_00000000, 0);
    checks++; if (misalign_err !== 1'b0) $display("FAIL trunc_err: got %0h want 0", misalign_err); else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_store();
    test_load();
    test_reset_mid_access();
    test_misalign();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
